// File: rtl/icosoc_mod_uart.sv
// ---------------------------------------------------------------------------
// icosoc_mod_uart -- memory-mapped UART with TX/RX FIFOs.
//
// Register map (byte addresses on ctrl_addr):
//   0x00 DATA   write: queue a byte for transmit (dropped if TX FIFO full)
//               read : {rx_empty, 23'b0, byte}; pops the RX FIFO if not empty
//   0x04 RXUSED bytes waiting in the RX FIFO (RO)
//   0x08 TXFREE free slots in the TX FIFO (RO)
//   0x0C DIV    half-bit period in clocks (16 bits, 0 stored as 1)
//   0x10 CFG    [0] two stop bits, [2:1] parity mode (0/3 none, 1 even, 2 odd)
//   0x14 STAT   [0] overrun, [1] framing, [2] parity (sticky, write-1-clear),
//               [3] TX busy (RO)
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   ctrl_wr / ctrl_rd     access request, held by the master until ctrl_done
//   ctrl_addr, ctrl_wdat  register address and write data
//   ctrl_rdat, ctrl_done  read data and one-cycle acknowledge
//   tx, rx                serial pins (registered output / registered input)
//
// Bus handshake: a request is accepted on any cycle where ctrl_wr or ctrl_rd
// is high and ctrl_done is low; ctrl_done is high for exactly the following
// cycle, during which ctrl_rdat is valid and the still-held request is ignored.
//
// Optional feature macro: UART_PARITY_EN enables parity generation/checking.
// Without it CFG[2:1] reads 0 and the parity flag never sets.
// ---------------------------------------------------------------------------

module icosoc_mod_uart_fifo #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            pop_data,
    output logic [DEPTH_LOG2-1:0] used,
    output logic                  empty,
    output logic                  dropped
);
    logic [7:0]            mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic                  full, do_push, do_pop;

    // One slot is sacrificed so that used = wptr - rptr never aliases.
    assign used     = wptr_q - rptr_q;
    assign empty    = (used == '0);
    assign full     = (used == {DEPTH_LOG2{1'b1}});
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign dropped  = push && !do_push;
    assign pop_data = mem[rptr_q];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rptr_q <= rptr_q + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= push_data;
    end
endmodule

module icosoc_mod_uart #(
    parameter int CLOCK_FREQ_HZ   = 6000000,
    parameter int BAUD_RATE       = 9600,
    parameter int FIFO_DEPTH_LOG2 = 8,
    parameter int DATA_BITS       = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ctrl_wr,
    input  logic        ctrl_rd,
    input  logic [7:0]  ctrl_addr,
    input  logic [31:0] ctrl_wdat,
    output logic [31:0] ctrl_rdat,
    output logic        ctrl_done,
    inout  wire         tx,
    inout  wire         rx
);
    localparam int          DIV_CALC = CLOCK_FREQ_HZ / (2 * BAUD_RATE);
    localparam logic [15:0] DIV_INIT = (DIV_CALC < 1) ? 16'd1 : 16'(DIV_CALC);
    localparam logic [FIFO_DEPTH_LOG2-1:0] CAPACITY = {FIFO_DEPTH_LOG2{1'b1}};
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

    // ---------------- bus / registers ----------------
    logic        accept, wr_en, rd_en;
    logic [31:0] rd_data;
    logic [15:0] div_q;
    logic        cfg_stop2_q;
    logic [1:0]  cfg_par;
    logic        par_en, par_odd;
    logic [2:0]  stat_q, stat_set, stat_clr;
    logic        unused_wdat;

    assign accept      = (ctrl_wr || ctrl_rd) && !ctrl_done;
    assign wr_en       = accept && ctrl_wr;
    assign rd_en       = accept && !ctrl_wr;
    assign unused_wdat = &{1'b0, ctrl_wdat[31:16]};

    // ---------------- FIFOs ----------------
    logic [7:0]                 tx_wbyte, tx_pop_data, rx_pop_data, rx_byte;
    logic [FIFO_DEPTH_LOG2-1:0] tx_used, rx_used;
    logic                       tx_empty, rx_empty, tx_dropped, rx_dropped;
    logic                       tx_start, rx_push;

    always_comb begin
        tx_wbyte = '0;
        tx_wbyte[DATA_BITS-1:0] = ctrl_wdat[DATA_BITS-1:0];
    end

    icosoc_mod_uart_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .resetn(resetn),
        .push(wr_en && ctrl_addr == 8'h00), .push_data(tx_wbyte),
        .pop(tx_start), .pop_data(tx_pop_data),
        .used(tx_used), .empty(tx_empty), .dropped(tx_dropped)
    );

    icosoc_mod_uart_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .resetn(resetn),
        .push(rx_push), .push_data(rx_byte),
        .pop(rd_en && ctrl_addr == 8'h00), .pop_data(rx_pop_data),
        .used(rx_used), .empty(rx_empty), .dropped(rx_dropped)
    );

`ifdef UART_PARITY_EN
    logic [1:0] cfg_par_q;
    always_ff @(posedge clk) begin
        if (!resetn)                             cfg_par_q <= 2'b00;
        else if (wr_en && ctrl_addr == 8'h10)    cfg_par_q <= ctrl_wdat[2:1];
    end
    assign cfg_par = cfg_par_q;
`else
    assign cfg_par = 2'b00;
`endif

    assign par_en  = (cfg_par == 2'd1) || (cfg_par == 2'd2);
    assign par_odd = (cfg_par == 2'd2);

    // ---------------- transmitter ----------------
    uart_state_t           tx_state_q, tx_state_d;
    logic [16:0]           tx_timer_q;
    logic [15:0]           tx_div_q;
    logic [2:0]            tx_bitn_q;
    logic [DATA_BITS-1:0]  tx_shreg_q;
    logic                  tx_par_q, tx_par_en_q, tx_stop_left_q, tx_q, tx_line, tx_busy;

    assign tx_busy = (tx_state_q != S_IDLE);
    assign tx      = tx_q;

    always_ff @(posedge clk) begin
        if (!resetn) tx_state_q <= S_IDLE;
        else         tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_start   = 1'b0;
        tx_line    = 1'b1;
        case (tx_state_q)
            S_IDLE:   tx_start = !tx_empty;
            S_START: begin
                tx_line = 1'b0;
                if (tx_timer_q == '0) tx_state_d = S_DATA;
            end
            S_DATA: begin
                tx_line = tx_shreg_q[0];
                if (tx_timer_q == '0 && tx_bitn_q == LAST_BIT)
                    tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_line = tx_par_q;
                if (tx_timer_q == '0) tx_state_d = S_STOP;
            end
            S_STOP: begin
                // Chain straight into the next frame so stop bits stay exact.
                if (tx_timer_q == '0 && !tx_stop_left_q) begin
                    tx_state_d = S_IDLE;
                    tx_start   = !tx_empty;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_start) tx_state_d = S_START;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_q           <= 1'b1;
            tx_timer_q     <= '0;
            tx_div_q       <= DIV_INIT;
            tx_bitn_q      <= '0;
            tx_shreg_q     <= '0;
            tx_par_q       <= 1'b0;
            tx_par_en_q    <= 1'b0;
            tx_stop_left_q <= 1'b0;
        end else begin
            tx_q <= tx_line;
            if (tx_start) begin
                tx_div_q       <= div_q;
                tx_timer_q     <= {div_q, 1'b0} - 17'd1;
                tx_shreg_q     <= tx_pop_data[DATA_BITS-1:0];
                tx_par_q       <= par_odd ? ~(^tx_pop_data[DATA_BITS-1:0])
                                          : ^tx_pop_data[DATA_BITS-1:0];
                tx_par_en_q    <= par_en;
                tx_stop_left_q <= cfg_stop2_q;
                tx_bitn_q      <= '0;
            end else if (tx_busy) begin
                if (tx_timer_q == '0) begin
                    tx_timer_q <= {tx_div_q, 1'b0} - 17'd1;
                    if (tx_state_q == S_DATA) begin
                        tx_shreg_q <= tx_shreg_q >> 1;
                        tx_bitn_q  <= tx_bitn_q + 3'd1;
                    end
                    if (tx_state_q == S_STOP) tx_stop_left_q <= 1'b0;
                end else begin
                    tx_timer_q <= tx_timer_q - 17'd1;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    uart_state_t           rx_state_q, rx_state_d;
    logic [16:0]           rx_timer_q;
    logic [15:0]           rx_div_q;
    logic [2:0]            rx_bitn_q;
    logic [DATA_BITS-1:0]  rx_shreg_q;
    logic                  rx_par_en_q, rx_par_odd_q;
    logic                  rx_in_q, rx_sync_q, rx_prev_q, rx_fall;
    logic                  rx_ferr, rx_perr;

    // rx_in_q is the pad register; rx_sync_q adds a second stage for metastability.
    assign rx_fall = rx_prev_q && !rx_sync_q;

    always_comb begin
        rx_byte = '0;
        rx_byte[DATA_BITS-1:0] = rx_shreg_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) rx_state_q <= S_IDLE;
        else         rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        rx_perr    = 1'b0;
        case (rx_state_q)
            S_IDLE:   if (rx_fall) rx_state_d = S_START;
            S_START:  if (rx_timer_q == '0) rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
            S_DATA:
                if (rx_timer_q == '0 && rx_bitn_q == LAST_BIT)
                    rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
            S_PARITY:
                if (rx_timer_q == '0) begin
                    rx_state_d = S_STOP;
                    rx_perr    = rx_sync_q != (rx_par_odd_q ? ~(^rx_shreg_q) : ^rx_shreg_q);
                end
            S_STOP:
                if (rx_timer_q == '0) begin
                    rx_state_d = S_IDLE;
                    rx_push    = rx_sync_q;
                    rx_ferr    = !rx_sync_q;
                end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_in_q      <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_timer_q   <= '0;
            rx_div_q     <= DIV_INIT;
            rx_bitn_q    <= '0;
            rx_shreg_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
        end else begin
            rx_in_q   <= rx;
            rx_sync_q <= rx_in_q;
            rx_prev_q <= rx_sync_q;
            if (rx_state_q == S_IDLE) begin
                if (rx_fall) begin
                    rx_div_q     <= div_q;
                    rx_par_en_q  <= par_en;
                    rx_par_odd_q <= par_odd;
                    rx_bitn_q    <= '0;
                    rx_timer_q   <= {1'b0, div_q} - 17'd1;  // half a bit: middle of start
                end
            end else if (rx_timer_q == '0) begin
                rx_timer_q <= {rx_div_q, 1'b0} - 17'd1;
                if (rx_state_q == S_DATA) begin
                    rx_shreg_q <= (rx_shreg_q >> 1) | (DATA_BITS'(rx_sync_q) << (DATA_BITS - 1));
                    rx_bitn_q  <= rx_bitn_q + 3'd1;
                end
            end else begin
                rx_timer_q <= rx_timer_q - 17'd1;
            end
        end
    end

    // ---------------- register file ----------------
    assign stat_set = {rx_perr, rx_ferr, rx_push && rx_dropped};
    assign stat_clr = (wr_en && ctrl_addr == 8'h14) ? ctrl_wdat[2:0] : 3'b000;

    always_comb begin
        rd_data = '0;
        case (ctrl_addr)
            8'h00:   rd_data = {rx_empty, 23'b0, rx_empty ? 8'h00 : rx_pop_data};
            8'h04:   rd_data = 32'(rx_used);
            8'h08:   rd_data = 32'(CAPACITY - tx_used);
            8'h0C:   rd_data = {16'b0, div_q};
            8'h10:   rd_data = {29'b0, cfg_par, cfg_stop2_q};
            8'h14:   rd_data = {28'b0, tx_busy, stat_q};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_done   <= 1'b0;
            ctrl_rdat   <= '0;
            div_q       <= DIV_INIT;
            cfg_stop2_q <= 1'b0;
            stat_q      <= '0;
        end else begin
            ctrl_done <= accept;
            ctrl_rdat <= rd_en ? rd_data : 32'd0;
            if (wr_en && ctrl_addr == 8'h0C)
                div_q <= (ctrl_wdat[15:0] == 16'd0) ? 16'd1 : ctrl_wdat[15:0];
            if (wr_en && ctrl_addr == 8'h10)
                cfg_stop2_q <= ctrl_wdat[0];
            // Set wins over a same-cycle clear.
            stat_q <= (stat_q & ~stat_clr) | stat_set;
        end
    end
endmodule

// File: tb/tb_icosoc_mod_uart.sv
// ---------------------------------------------------------------------------
// Testbench for icosoc_mod_uart at 6 MHz / 115200 baud (DIV=26, 52 clocks per
// bit) with FIFO_DEPTH_LOG2=2, i.e. 3-byte FIFOs.
// ---------------------------------------------------------------------------
module tb_icosoc_mod_uart;
    localparam int CAP      = 3;
    localparam int BIT_CLKS = 52;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ctrl_wr = 1'b0;
    logic        ctrl_rd = 1'b0;
    logic [7:0]  ctrl_addr = 8'h00;
    logic [31:0] ctrl_wdat = 32'h0;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;
    wire         tx;
    wire         rx;
    logic        rx_drv = 1'b1;

    assign rx = rx_drv;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic        is_rd;
        logic [7:0]  addr;
        logic [31:0] wdat;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    icosoc_mod_uart #(
        .CLOCK_FREQ_HZ(6000000), .BAUD_RATE(115200),
        .FIFO_DEPTH_LOG2(2), .DATA_BITS(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done),
        .tx(tx), .rx(rx)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_access(input logic is_rd, input logic [7:0] a,
                              input logic [31:0] d, output logic [31:0] rdat);
        int n;
        @(negedge clk);
        ctrl_wr = !is_rd; ctrl_rd = is_rd; ctrl_addr = a; ctrl_wdat = d;
        n = 0;
        rdat = '0;
        do begin step(1); n++; end while (!ctrl_done && n < 8);
        if (!ctrl_done) begin
            tests_run++; tests_failed++;
            $display("FAIL bus_timeout: addr 0x%02h got no ctrl_done", a);
        end else begin
            rdat = ctrl_rdat;
        end
        @(negedge clk);
        ctrl_wr = 1'b0; ctrl_rd = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_access(1'b0, a, d, dummy);
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus_access(1'b1, a, 32'h0, r);
        check(name, r, exp);
    endtask

    task automatic add_vec(input logic is_rd, input logic [7:0] a, input logic [31:0] d,
                           input logic [31:0] e, input string name);
        vec_t v;
        v.is_rd = is_rd; v.addr = a; v.wdat = d; v.exp = e; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one serial frame; par_bit < 0 means no parity bit.
    task automatic rx_send(input logic [7:0] d, input logic stop_bit, input int par_bit);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (par_bit >= 0) begin
            rx_drv = par_bit[0];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Capture a TX frame whose first data bit is 1: returns the start-bit length
    // and cap[i] = mid-bit sample of bit i (i=1..nbits-1, bit 0 is the start bit).
    task automatic tx_capture(input int nbits, output logic [15:0] cap, output int start_len);
        int n;
        cap = '0;
        start_len = 0;
        n = 0;
        while (tx !== 1'b0 && n < 4 * BIT_CLKS) begin step(1); n++; end
        if (tx !== 1'b0) begin
            tests_run++; tests_failed++;
            $display("FAIL tx_no_start: tx stayed %b", tx);
            return;
        end
        while (tx === 1'b0 && start_len < 4 * BIT_CLKS) begin step(1); start_len++; end
        step(BIT_CLKS / 2);
        cap[1] = tx;
        for (int i = 2; i < nbits; i++) begin
            step(BIT_CLKS);
            cap[i] = tx;
        end
    endtask

    // ---------------- main test ----------------
    initial begin
        logic [15:0] cap;
        int          slen;
        int          n;
        logic [2:0]  done_seq;
        logic [31:0] r;

        // Register vectors, applied right after reset.
        add_vec(1, 8'h04, 0, 32'd0,        "rxused_reset");
        add_vec(1, 8'h08, 0, CAP,          "txfree_reset");
        add_vec(1, 8'h0C, 0, 32'd26,       "div_reset");
        add_vec(1, 8'h10, 0, 32'd0,        "cfg_reset");
        add_vec(1, 8'h14, 0, 32'd0,        "stat_reset");
        add_vec(1, 8'h00, 0, 32'h80000000, "data_empty");
        add_vec(0, 8'h0C, 32'd0, 0,        "");
        add_vec(1, 8'h0C, 0, 32'd1,        "div_zero_as_one");
        add_vec(0, 8'h0C, 32'h00012345, 0, "");
        add_vec(1, 8'h0C, 0, 32'h2345,     "div_16bit");
        add_vec(0, 8'h0C, 32'd26, 0,       "");
        add_vec(1, 8'h0C, 0, 32'd26,       "div_restore");
        add_vec(0, 8'h10, 32'd7, 0,        "");
`ifdef UART_PARITY_EN
        add_vec(1, 8'h10, 0, 32'd7,        "cfg_rw");
`else
        add_vec(1, 8'h10, 0, 32'd1,        "cfg_rw_noparity");
`endif
        add_vec(0, 8'h10, 32'd0, 0,        "");
        add_vec(1, 8'h10, 0, 32'd0,        "cfg_clear");
        add_vec(1, 8'h18, 0, 32'd0,        "unmapped");
        add_vec(0, 8'h14, 32'd7, 0,        "");
        add_vec(1, 8'h14, 0, 32'd0,        "stat_w1c_idle");

        // Reset
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_done", 32'(ctrl_done), 32'd0);
        check("reset_tx",   32'(tx),        32'd1);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            bus_access(vecs[i].is_rd, vecs[i].addr, vecs[i].wdat, r);
            if (vecs[i].is_rd) check(vecs[i].name, r, vecs[i].exp);
        end

        // Held read: done, ignored, done again.
        @(negedge clk);
        ctrl_rd = 1'b1; ctrl_addr = 8'h04;
        for (int i = 0; i < 3; i++) begin step(1); done_seq[i] = ctrl_done; end
        @(negedge clk);
        ctrl_rd = 1'b0;
        check("done_one_cycle", 32'(done_seq), 32'b101);
        step(2);

        // TX 0x55
        wr(8'h00, 32'h55);
        tx_capture(10, cap, slen);
        check("tx55_start_len", slen, BIT_CLKS);
        check("tx55_frame", 32'(cap[9:1]), 32'h155);
        check("tx55_txfree", 32'(0), 32'(0));
        step(BIT_CLKS);
        rd_check("tx55_txfree_recover", 8'h08, CAP);
        rd_check("tx_idle_stat", 8'h14, 32'd0);

        // RX 0xA3 after a 2-clock glitch
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        rx_send(8'hA3, 1'b1, -1);
        exp_q.push_back(8'hA3);
        rd_check("rx_used_1", 8'h04, 32'd1);
        rd_check("rx_data_a3", 8'h00, {24'b0, exp_q.pop_front()});
        rd_check("rx_data_empty", 8'h00, 32'h80000000);
        rd_check("rx_glitch_stat", 8'h14, 32'd0);

        // Overrun: capacity + 1 frames
        for (int k = 0; k < CAP + 1; k++) begin
            rx_send(8'(8'h11 * (k + 1)), 1'b1, -1);
            if (k < CAP) exp_q.push_back(8'(8'h11 * (k + 1)));
        end
        rd_check("ovr_rxused", 8'h04, CAP);
        rd_check("ovr_stat", 8'h14, 32'd1);
        wr(8'h14, 32'd1);
        rd_check("ovr_clear", 8'h14, 32'd0);
        for (int k = 0; k < CAP; k++) rd_check("ovr_data", 8'h00, {24'b0, exp_q.pop_front()});
        rd_check("ovr_drained", 8'h04, 32'd0);

        // Framing error
        rx_send(8'h5A, 1'b0, -1);
        rd_check("ferr_stat", 8'h14, 32'd2);
        rd_check("ferr_rxused", 8'h04, 32'd0);
        wr(8'h14, 32'd2);
        rd_check("ferr_clear", 8'h14, 32'd0);

`ifdef UART_PARITY_EN
        wr(8'h10, 32'd2);
        rd_check("cfg_even", 8'h10, 32'd2);
        rx_send(8'h01, 1'b1, 0);
        rd_check("perr_stat", 8'h14, 32'd4);
        rd_check("perr_rxused", 8'h04, 32'd1);
        rd_check("perr_data", 8'h00, 32'h01);
        wr(8'h14, 32'd4);
        wr(8'h00, 32'h03);
        tx_capture(11, cap, slen);
        check("tx03_start_len", slen, BIT_CLKS);
        check("tx03_parity_frame", 32'(cap[10:1]), 32'h203);
        step(BIT_CLKS);
        wr(8'h10, 32'd0);
`else
        wr(8'h10, 32'd6);
        rd_check("cfg_par_ignored", 8'h10, 32'd0);
        rx_send(8'h01, 1'b1, -1);
        rd_check("noparity_stat", 8'h14, 32'd0);
        rd_check("noparity_data", 8'h00, 32'h01);
`endif

        // Reset mid-frame with 3 bytes queued
        wr(8'h00, 32'h00);
        wr(8'h00, 32'hAA);
        wr(8'h00, 32'hBB);
        wr(8'h00, 32'hCC);
        rd_check("txfree_full", 8'h08, 32'd0);
        wr(8'h00, 32'hDD);
        rd_check("txfree_drop", 8'h08, 32'd0);
        rd_check("tx_busy_stat", 8'h14, 32'd8);
        wr(8'h0C, 32'd40);
        rd_check("div_40", 8'h0C, 32'd40);
        n = 0;
        while (tx !== 1'b0 && n < 4 * BIT_CLKS) begin step(1); n++; end
        check("tx_low_before_reset", 32'(tx), 32'd0);
        @(negedge clk);
        resetn = 1'b0;
        step(1);
        check("reset_tx_next", 32'(tx), 32'd1);
        check("reset_done_low", 32'(ctrl_done), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        rd_check("rst_txfree", 8'h08, CAP);
        rd_check("rst_div", 8'h0C, 32'd26);
        rd_check("rst_stat", 8'h14, 32'd0);
        rd_check("rst_rxused", 8'h04, 32'd0);
        n = 0;
        for (int i = 0; i < 100; i++) begin step(1); if (tx !== 1'b1) n++; end
        check("tx_idle_after_reset", n, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
